skinny_tk1_sched: RTL and testbench



---
 rtl/skinny_tk1_sched.sv | 87 ++++++++
 tb/tb_skinny_tk1_sched.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/skinny_tk1_sched.sv
// SKINNY TK1 tweakey scheduler: loads a 128-bit tweakey and streams NR round
// tweakeys (cells 8..15), stepping the register through PT per accepted key.
module skinny_tk1_sched #(
  parameter int unsigned NR = 40,
  parameter int unsigned W  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tk_valid,
  output logic         tk_ready,
  input  logic [127:0] tk_in,
  input  logic         abort,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [63:0]  rk,
  output logic [5:0]   rk_idx,
  output logic         rk_last,
  output logic         busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [5:0] LAST = 6'(NR - 1);
  localparam int unsigned PMAP [16] = '{8, 9, 10, 11, 12, 13, 14, 15,
                                        4, 3, 1, 5, 2, 7, 0, 6};

  state_t       state, state_d;
  logic [127:0] tk_reg, tk_reg_d;
  logic [5:0]   idx_d;

  // Cell i of the result takes cell PMAP[i] of the input.
  function automatic logic [127:0] pt(input logic [127:0] t);
    logic [127:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++)
      o[W*i +: W] = t[W*PMAP[i] +: W];
    return o;
  endfunction

  always_comb begin
    state_d  = state;
    tk_reg_d = tk_reg;
    idx_d    = rk_idx;
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state)
        IDLE: if (tk_valid) begin
          tk_reg_d = tk_in;
          idx_d    = '0;
          state_d  = RUN;
        end
        RUN: if (rk_ready) begin
          // The final key leaves tk_reg untouched rather than stepping it.
          if (rk_idx == LAST) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            tk_reg_d = pt(tk_reg);
            idx_d    = rk_idx + 6'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      tk_reg <= '0;
      rk_idx <= '0;
    end else begin
      state  <= state_d;
      tk_reg <= tk_reg_d;
      rk_idx <= idx_d;
    end
  end

  assign tk_ready = (state == IDLE);
  assign rk_valid = (state == RUN);
  assign busy     = (state == RUN);
  assign rk       = tk_reg[127:64];
  assign rk_last  = (state == RUN) && (rk_idx == LAST);

endmodule

// File: tb/tb_skinny_tk1_sched.sv
// Randomized self-checking bench for skinny_tk1_sched (NR=40 and NR=16 instances)
// against a cell-index permutation model of the TK1 schedule.
module tb_skinny_tk1_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tk_valid, tk_ready, abort, rk_valid, rk_ready, rk_last, busy;
  logic [127:0] tk_in;
  logic [63:0]  rk;
  logic [5:0]   rk_idx;
  logic         tk_valid_b, tk_ready_b, abort_b, rk_valid_b, rk_ready_b, rk_last_b, busy_b;
  logic [127:0] tk_in_b;
  logic [63:0]  rk_b;
  logic [5:0]   rk_idx_b;

  int errors = 0;
  int checks = 0;
  int perm [16] = '{8, 9, 10, 11, 12, 13, 14, 15, 4, 3, 1, 5, 2, 7, 0, 6};

  always #5 clk = ~clk;

  skinny_tk1_sched #(.NR(40), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .tk_valid(tk_valid), .tk_ready(tk_ready), .tk_in(tk_in),
    .abort(abort), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk), .rk_idx(rk_idx),
    .rk_last(rk_last), .busy(busy));

  skinny_tk1_sched #(.NR(16), .W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .tk_valid(tk_valid_b), .tk_ready(tk_ready_b), .tk_in(tk_in_b),
    .abort(abort_b), .rk_valid(rk_valid_b), .rk_ready(rk_ready_b), .rk(rk_b), .rk_idx(rk_idx_b),
    .rk_last(rk_last_b), .busy(busy_b));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Round r key: output cell c holds original cell perm^r(c).
  function automatic logic [63:0] exp_key(input logic [127:0] tk, input int r);
    logic [63:0] k;
    int src;
    k = '0;
    for (int c = 8; c < 16; c++) begin
      src = c;
      for (int n = 0; n < r; n++) src = perm[src];
      k[8*(c-8) +: 8] = tk[8*src +: 8];
    end
    return k;
  endfunction

  function automatic logic [127:0] rand_tk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic load(input logic [127:0] tk);
    check("ld_ready", tk_ready, 1'b1);
    tk_valid = 1'b1;
    tk_in    = tk;
    @(posedge clk);
    @(negedge clk);
    tk_valid = 1'b0;
  endtask

  task automatic stream(input logic [127:0] tk, input int pct);
    int idx = 0;
    int cyc = 0;
    while (idx < 40 && cyc < 2000) begin
      check("rk_valid", rk_valid, 1'b1);
      check("rk_idx", rk_idx, idx);
      check("rk", rk, exp_key(tk, idx));
      check("rk_last", rk_last, idx == 39);
      check("busy", busy, 1'b1);
      check("tk_ready_run", tk_ready, 1'b0);
      if (idx % 16 == 0) check("period", rk, tk[127:64]);
      rk_ready = ($urandom_range(99) < pct);
      @(posedge clk);
      if (rk_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    if (idx != 40) check("timeout", idx, 40);
    rk_ready = 1'b0;
    check("end_valid", rk_valid, 1'b0);
    check("end_ready", tk_ready, 1'b1);
    check("end_busy", busy, 1'b0);
    check("end_rk", rk, exp_key(tk, 39));
  endtask

  task automatic stream16(input logic [127:0] tk);
    int idx = 0;
    check("b_ld_ready", tk_ready_b, 1'b1);
    tk_valid_b = 1'b1;
    tk_in_b    = tk;
    @(posedge clk);
    @(negedge clk);
    tk_valid_b = 1'b0;
    rk_ready_b = 1'b1;
    while (idx < 16) begin
      check("b_rk_valid", rk_valid_b, 1'b1);
      check("b_rk_idx", rk_idx_b, idx);
      check("b_rk", rk_b, exp_key(tk, idx));
      check("b_rk_last", rk_last_b, idx == 15);
      @(posedge clk);
      @(negedge clk);
      idx++;
    end
    rk_ready_b = 1'b0;
    check("b_end_valid", rk_valid_b, 1'b0);
    check("b_end_ready", tk_ready_b, 1'b1);
    check("b_end_rk", rk_b, exp_key(tk, 15));
  endtask

  initial begin
    logic [127:0] tka, tkb;
    rst_n = 1'b0;
    {tk_valid, abort, rk_ready, tk_valid_b, abort_b, rk_ready_b} = '0;
    tk_in = '0;
    tk_in_b = '0;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tk_ready", tk_ready, 1'b1);
    check("rst_rk_valid", rk_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rk", rk, 64'h0);
    check("rst_idx", rk_idx, 6'd0);
    check("rst_last", rk_last, 1'b0);
    check("rst_b_ready", tk_ready_b, 1'b1);
    check("rst_b_valid", rk_valid_b, 1'b0);
    rst_n = 1'b1;

    // fixed vector: byte i = i
    for (int i = 0; i < 16; i++) tka[8*i +: 8] = 8'(i);
    load(tka);
    rk_ready = 1'b1;
    check("t2_rk0", rk, 64'h0F0E0D0C0B0A0908);
    check("t2_idx0", rk_idx, 6'd0);
    @(posedge clk);
    @(negedge clk);
    check("t2_rk1", rk, 64'h0600070205010304);
    check("t2_idx1", rk_idx, 6'd1);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    rk_ready = 1'b0;
    check("t2_abort_idle", tk_ready, 1'b1);

    // NR=16 instance, full rate
    stream16(rand_tk());
    stream16(rand_tk());

    // NR=40 with random stalls, then full rate
    for (int k = 0; k < 3; k++) begin
      tka = rand_tk();
      load(tka);
      stream(tka, 50);
    end
    tka = rand_tk();
    load(tka);
    stream(tka, 100);

    // abort at idx 7 discards the coincident handshake
    tka = rand_tk();
    load(tka);
    rk_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("t5_idx7", rk_idx, 6'd7);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    rk_ready = 1'b0;
    check("t5_valid", rk_valid, 1'b0);
    check("t5_ready", tk_ready, 1'b1);
    check("t5_busy", busy, 1'b0);
    check("t5_idx", rk_idx, 6'd0);
    check("t5_hold", rk, exp_key(tka, 7));
    tkb = rand_tk();
    load(tkb);
    stream(tkb, 100);

    // abort with tk_valid in IDLE blocks the load
    tk_valid = 1'b1;
    tk_in = rand_tk();
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tk_valid = 1'b0;
    abort = 1'b0;
    check("abort_ld_busy", busy, 1'b0);
    check("abort_ld_ready", tk_ready, 1'b1);

    // reset mid-run clears tk_reg
    tka = rand_tk();
    load(tka);
    rk_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rk_ready = 1'b0;
    check("mrst_rk", rk, 64'h0);
    check("mrst_valid", rk_valid, 1'b0);
    check("mrst_idx", rk_idx, 6'd0);
    check("mrst_busy", busy, 1'b0);

    // tk_valid held through RUN: reload exactly one cycle after last handshake
    tka = rand_tk();
    tkb = rand_tk();
    tk_valid = 1'b1;
    tk_in = tka;
    @(posedge clk);
    @(negedge clk);
    tk_in = tkb;
    rk_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      check("t6_idx", rk_idx, i);
      check("t6_rk", rk, exp_key(tka, i));
      @(posedge clk);
      @(negedge clk);
    end
    check("t6_gap_valid", rk_valid, 1'b0);
    check("t6_gap_ready", tk_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("t6_reload_valid", rk_valid, 1'b1);
    check("t6_reload_idx", rk_idx, 6'd0);
    check("t6_reload_rk", rk, tkb[127:64]);
    tk_valid = 1'b0;
    rk_ready = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
